// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encodings and
// the elaboration-time clog2 helper used to size the digit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand and result handshake bundle for serial_sub; the block itself
// connects through the slave view, the producer/consumer side through master.
interface serial_sub_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: x - y - bi, producing difference and borrow.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor d = a - b - bin, DIGIT bits per clock LSB-first,
// with the borrow carried between cycles in a register.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W     = 8,
    parameter int DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int NCYC  = W / DIGIT;
    localparam int CNT_W = clog2(NCYC) + 1;

    generate
        if ((W % DIGIT) != 0) begin : g_bad_digit
            $error("serial_sub: W must be a multiple of DIGIT");
        end
    endgenerate

    state_e             state_r;
    state_e             state_s;
    logic [CNT_W-1:0]   count_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               borrow_r;
    logic [W-1:0]       res_r;
    logic [1:0]         sign_r;
    logic [W-1:0]       d_r;
    logic               bout_r;
    logic               ovf_r;

    logic [DIGIT-1:0]   diff_s;
    logic [DIGIT:0]     chain_s;
    logic [W-1:0]       res_next_s;
    logic               last_s;

    assign chain_s[0] = borrow_r;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            full_sub u_cell (
                .x    (a_r[gi]),
                .y    (b_r[gi]),
                .bi   (chain_s[gi]),
                .diff (diff_s[gi]),
                .bo   (chain_s[gi+1])
            );
        end
    endgenerate

    // New difference digits enter at the MSB end so the LSB digit lands at bit 0 after NCYC shifts.
    assign res_next_s = (res_r >> DIGIT) | (W'(diff_s) << (W - DIGIT));
    assign last_s     = (count_r == CNT_W'(NCYC - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode for the accept / compute / present sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow chain register, result accumulation and output capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= '0;
            a_r      <= '0;
            b_r      <= '0;
            borrow_r <= 1'b0;
            res_r    <= '0;
            sign_r   <= 2'b00;
            d_r      <= '0;
            bout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        borrow_r <= bus.bin;
                        count_r  <= '0;
                        res_r    <= '0;
                        sign_r   <= {bus.a[W-1], bus.b[W-1]};
                    end
                end
                RUN: begin
                    a_r      <= a_r >> DIGIT;
                    b_r      <= b_r >> DIGIT;
                    borrow_r <= chain_s[DIGIT];
                    res_r    <= res_next_s;
                    count_r  <= count_r + CNT_W'(1);
                    if (last_s) begin
                        d_r    <= res_next_s;
                        bout_r <= chain_s[DIGIT];
                        // Overflow only when signs differ and the result sign departs from the minuend.
                        ovf_r  <= (sign_r[1] != sign_r[0]) && (res_next_s[W-1] != sign_r[1]);
                    end
                end
                DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.d         = d_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed and random W=8/DIGIT=2 traffic
// plus an exhaustive W=4 sweep over DIGIT=1,2,4, against an arithmetic model.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.W(8)) bus8 ();
    serial_sub_if #(.W(4)) bus41 ();
    serial_sub_if #(.W(4)) bus42 ();
    serial_sub_if #(.W(4)) bus44 ();

    serial_sub #(.W(8), .DIGIT(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_sub #(.W(4), .DIGIT(1)) u41 (.clk(clk), .rst_n(rst_n), .bus(bus41));
    serial_sub #(.W(4), .DIGIT(2)) u42 (.clk(clk), .rst_n(rst_n), .bus(bus42));
    serial_sub #(.W(4), .DIGIT(4)) u44 (.clk(clk), .rst_n(rst_n), .bus(bus44));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned difference for d/bout, signed range test for ovf.
    function automatic void model(input int w, input int a, input int b, input int bi,
                                  output logic [31:0] d, output logic [31:0] bo,
                                  output logic [31:0] ov);
        int m, h, r, sa, sb, sr;
        m  = 1 << w;
        h  = m / 2;
        r  = a - b - bi;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        sr = sa - sb - bi;
        d  = 32'((r + 2 * m) % m);
        bo = (r < 0) ? 32'd1 : 32'd0;
        ov = ((sr < -h) || (sr > h - 1)) ? 32'd1 : 32'd0;
    endfunction

    task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input int hold, input logic poke);
        logic [31:0] ed, eb, eo;
        logic [7:0]  d0;
        logic        b0, o0;
        int          lat;
        model(8, int'(a), int'(b), int'(bi), ed, eb, eo);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus8.in_ready), 32'd1);
        bus8.a = a; bus8.b = b; bus8.bin = bi; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus8.out_valid) begin
                lat = c;
                break;
            end
        end
        chk("latency8", 32'(lat), 32'd4);
        chk("d8", 32'(bus8.d), ed);
        chk("bout8", 32'(bus8.bout), eb);
        chk("ovf8", 32'(bus8.ovf), eo);
        d0 = bus8.d; b0 = bus8.bout; o0 = bus8.ovf;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                bus8.a = ~a; bus8.b = ~b; bus8.in_valid = 1'b1;
            end
            @(negedge clk);
            chk("hold_d", 32'(bus8.d), 32'(d0));
            chk("hold_bout_ovf", 32'({bus8.bout, bus8.ovf}), 32'({b0, o0}));
            chk("hold_in_ready", 32'(bus8.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus8.out_valid), 32'd1);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        chk("release_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("after_done_d", 32'(bus8.d), ed);
    endtask

    task automatic do4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        logic [31:0] ed, eb, eo;
        int          l1, l2, l4;
        logic [3:0]  d1, d2, d4;
        logic [1:0]  f1, f2, f4;
        model(4, int'(a), int'(b), int'(bi), ed, eb, eo);
        @(negedge clk);
        bus41.a = a; bus41.b = b; bus41.bin = bi; bus41.in_valid = 1'b1;
        bus42.a = a; bus42.b = b; bus42.bin = bi; bus42.in_valid = 1'b1;
        bus44.a = a; bus44.b = b; bus44.bin = bi; bus44.in_valid = 1'b1;
        @(negedge clk);
        bus41.in_valid = 1'b0; bus42.in_valid = 1'b0; bus44.in_valid = 1'b0;
        l1 = 0; l2 = 0; l4 = 0;
        d1 = '0; d2 = '0; d4 = '0; f1 = '0; f2 = '0; f4 = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus41.out_valid && l1 == 0) begin
                l1 = c; d1 = bus41.d; f1 = {bus41.bout, bus41.ovf};
            end
            if (bus42.out_valid && l2 == 0) begin
                l2 = c; d2 = bus42.d; f2 = {bus42.bout, bus42.ovf};
            end
            if (bus44.out_valid && l4 == 0) begin
                l4 = c; d4 = bus44.d; f4 = {bus44.bout, bus44.ovf};
            end
        end
        chk("sweep_lat_d1", 32'(l1), 32'd4);
        chk("sweep_lat_d2", 32'(l2), 32'd2);
        chk("sweep_lat_d4", 32'(l4), 32'd1);
        chk("sweep_d_d1", 32'(d1), ed);
        chk("sweep_d_d2", 32'(d2), ed);
        chk("sweep_d_d4", 32'(d4), ed);
        chk("sweep_flags_d1", 32'(f1), {eb[30:0], eo[0]});
        chk("sweep_flags_d2", 32'(f2), {eb[30:0], eo[0]});
        chk("sweep_flags_d4", 32'(f4), {eb[30:0], eo[0]});
    endtask

    initial begin
        int highs;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b0;
        bus41.in_valid = 1'b0; bus41.a = '0; bus41.b = '0; bus41.bin = 1'b0; bus41.out_ready = 1'b1;
        bus42.in_valid = 1'b0; bus42.a = '0; bus42.b = '0; bus42.bin = 1'b0; bus42.out_ready = 1'b1;
        bus44.in_valid = 1'b0; bus44.a = '0; bus44.b = '0; bus44.bin = 1'b0; bus44.out_ready = 1'b1;

        #1;
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_d", 32'(bus8.d), 32'd0);
        chk("rst_bout_ovf", 32'({bus8.bout, bus8.ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do8(8'h05, 8'h03, 1'b0, 0, 1'b0);
        do8(8'h00, 8'h01, 1'b0, 0, 1'b0);
        do8(8'h10, 8'h10, 1'b1, 0, 1'b0);
        do8(8'h80, 8'h01, 1'b0, 0, 1'b0);
        do8(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
        do8(8'h3C, 8'h5A, 1'b1, 10, 1'b1);

        // Reset two cycles into RUN; d is non-zero from the previous result.
        @(negedge clk);
        bus8.a = 8'hC3; bus8.b = 8'h12; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_d", 32'(bus8.d), 32'd0);
        chk("midrun_flags", 32'({bus8.bout, bus8.ovf}), 32'd0);
        chk("midrun_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("midrun_in_ready", 32'(bus8.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus8.out_valid) highs++;
        end
        chk("midrun_no_valid", 32'(highs), 32'd0);
        do8(8'h09, 8'h04, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        for (int v = 0; v < 512; v++) begin
            do4(4'(v >> 5), 4'(v >> 1), 1'(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
